// File: rtl/morse_pkg.sv
// Shared types, unit constants and the ASCII-to-Morse lookup for the Morse keyer.
package morse_pkg;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] bits;
   } morse_code_t;

   typedef struct packed {
      logic        supported;
      logic        is_space;
      morse_code_t code;
   } morse_lookup_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ALIGN    = 3'd1,
      MARK     = 3'd2,
      SPACE    = 3'd3,
      CHAR_GAP = 3'd4,
      WORD_GAP = 3'd5
   } keyer_state_t;

   localparam logic [2:0] DOT_UNITS      = 3'd1;
   localparam logic [2:0] DASH_UNITS     = 3'd3;
   localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
   localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;

   // Codes are left-aligned: bits[4] is the first element sent, 1 = dash.
   function automatic morse_code_t letter_code(input logic [4:0] idx);
      morse_code_t m;
      case (idx)
         5'd1:    m = {3'd2, 5'b01000};
         5'd2:    m = {3'd4, 5'b10000};
         5'd3:    m = {3'd4, 5'b10100};
         5'd4:    m = {3'd3, 5'b10000};
         5'd5:    m = {3'd1, 5'b00000};
         5'd6:    m = {3'd4, 5'b00100};
         5'd7:    m = {3'd3, 5'b11000};
         5'd8:    m = {3'd4, 5'b00000};
         5'd9:    m = {3'd2, 5'b00000};
         5'd10:   m = {3'd4, 5'b01110};
         5'd11:   m = {3'd3, 5'b10100};
         5'd12:   m = {3'd4, 5'b01000};
         5'd13:   m = {3'd2, 5'b11000};
         5'd14:   m = {3'd2, 5'b10000};
         5'd15:   m = {3'd3, 5'b11100};
         5'd16:   m = {3'd4, 5'b01100};
         5'd17:   m = {3'd4, 5'b11010};
         5'd18:   m = {3'd3, 5'b01000};
         5'd19:   m = {3'd3, 5'b00000};
         5'd20:   m = {3'd1, 5'b10000};
         5'd21:   m = {3'd3, 5'b00100};
         5'd22:   m = {3'd4, 5'b00010};
         5'd23:   m = {3'd3, 5'b01100};
         5'd24:   m = {3'd4, 5'b10010};
         5'd25:   m = {3'd4, 5'b10110};
         5'd26:   m = {3'd4, 5'b11000};
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic morse_lookup_t char_to_morse(input logic [7:0] c);
      morse_lookup_t r;
      logic [7:0]    u;
      logic [3:0]    d;
      r = '0;
      u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
      d = u[3:0];
      if (u == 8'h20) begin
         r.supported = 1'b1;
         r.is_space  = 1'b1;
      end else if (u >= 8'h30 && u <= 8'h39) begin
         // Digits 0-5 are d dots then dashes; 6-9 are (d-5) dashes then dots.
         r.supported = 1'b1;
         r.code.len  = 3'd5;
         if (d <= 4'd5) begin
            r.code.bits = 5'b11111 >> d;
         end else begin
            r.code.bits = ~(5'b11111 >> (d - 4'd5));
         end
      end else if (u >= 8'h41 && u <= 8'h5A) begin
         r.supported = 1'b1;
         r.code      = letter_code(u[4:0]);
      end else begin
         r.supported = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/morse_sidetone.sv
// Square-wave sidetone that runs only while the key is down; built with MORSE_SIDETONE_EN.
`ifdef MORSE_SIDETONE_EN
module morse_sidetone #(
   parameter int TONE_DIV   = 12500,
   parameter int TONE_WIDTH = 14
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_tone
);

   logic [TONE_WIDTH-1:0] cnt_q;
   logic                  tone_q;

   // Half-period counter; held cleared while the key is up so each mark starts in phase.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (!i_key) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (cnt_q == TONE_WIDTH'(TONE_DIV - 1)) begin
         cnt_q  <= '0;
         tone_q <= ~tone_q;
      end else begin
         cnt_q  <= cnt_q + TONE_WIDTH'(1);
      end
   end

   assign o_tone = tone_q;

endmodule
`endif

// File: rtl/morse_keyer.sv
// ASCII-to-Morse keyer timed by rising edges of the unit divider.
// Optional sidetone output o_tone is enabled by defining MORSE_SIDETONE_EN.
module morse_keyer
   import morse_pkg::*;
#(
   parameter int WORD_EXTRA = 4
`ifdef MORSE_SIDETONE_EN
  ,parameter int TONE_DIV   = 12500
  ,parameter int TONE_WIDTH = 14
`endif
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_unit_clk,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_key,
   output logic       o_busy,
   output logic       o_err
`ifdef MORSE_SIDETONE_EN
  ,output logic       o_tone
`endif
);

   keyer_state_t  state_q;
   logic          unit_q;
   logic [2:0]    cnt_q;
   logic [2:0]    rem_q;
   logic [4:0]    bits_q;
   logic          key_q;
   logic          ready_q;
   logic          busy_q;
   logic          err_q;
   logic          tick_s;
   logic          accept_s;
   logic [2:0]    elem_units_s;
   morse_lookup_t lk_s;

   assign tick_s       = i_unit_clk & ~unit_q;
   assign accept_s     = i_valid & ready_q;
   assign lk_s         = char_to_morse(i_data);
   assign elem_units_s = bits_q[4] ? DASH_UNITS : DOT_UNITS;

   // Keying state machine; ready/busy are registered alongside every state change.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         unit_q  <= 1'b0;
         cnt_q   <= 3'd0;
         rem_q   <= 3'd0;
         bits_q  <= 5'd0;
         key_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unit_q <= i_unit_clk;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= 3'd0;
               if (accept_s) begin
                  if (!lk_s.supported) begin
                     err_q <= 1'b1;
                  end else begin
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     if (lk_s.is_space) begin
                        state_q <= WORD_GAP;
                     end else begin
                        rem_q   <= lk_s.code.len;
                        bits_q  <= lk_s.code.bits;
                        state_q <= ALIGN;
                     end
                  end
               end
            end
            ALIGN: begin
               if (tick_s) begin
                  key_q   <= 1'b1;
                  cnt_q   <= 3'd0;
                  state_q <= MARK;
               end
            end
            MARK: begin
               if (tick_s) begin
                  if (cnt_q == elem_units_s - 3'd1) begin
                     key_q   <= 1'b0;
                     cnt_q   <= 3'd0;
                     state_q <= (rem_q != 3'd1) ? SPACE : CHAR_GAP;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            SPACE: begin
               if (tick_s) begin
                  if (cnt_q == ELEM_GAP_UNITS - 3'd1) begin
                     key_q   <= 1'b1;
                     bits_q  <= {bits_q[3:0], 1'b0};
                     rem_q   <= rem_q - 3'd1;
                     cnt_q   <= 3'd0;
                     state_q <= MARK;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            CHAR_GAP, WORD_GAP: begin
               if (tick_s) begin
                  if (cnt_q == ((state_q == CHAR_GAP) ? CHAR_GAP_UNITS - 3'd1
                                                      : 3'(WORD_EXTRA - 1))) begin
                     cnt_q   <= 3'd0;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            default: begin
               key_q   <= 1'b0;
               cnt_q   <= 3'd0;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_key   = key_q;
   assign o_busy  = busy_q;
   assign o_err   = err_q;

`ifdef MORSE_SIDETONE_EN
   morse_sidetone #(
      .TONE_DIV   (TONE_DIV),
      .TONE_WIDTH (TONE_WIDTH)
   ) u_sidetone (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key   (key_q),
      .o_tone  (o_tone)
   );
`endif

endmodule
